// File: rtl/evenzeroes_struct_imp.sv
// Clocked dual-rail "even zeroes" parity tracker: four-phase RTZ handshake on
// {bit1,bit0}, answering each token with the running zero-count parity on {parity1,parity0}.

module evenzeroes_struct_imp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];
endmodule

module evenzeroes_struct_imp #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit0,
    input  logic bit1,
    output logic parity0,
    output logic parity1
);
    localparam int STAGES = SYNC_STAGES - 1;

    typedef enum logic [1:0] {
        WAIT_NULL = 2'd0,
        IDLE      = 2'd1,
        ACK       = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t      state;
    logic        zp;
    logic [1:0]  rails_s;
    logic [STAGES:0] vld_pipe;

    evenzeroes_struct_imp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bit1, bit0}),
        .q     (rails_s)
    );

    // Synchronizers come out of reset holding 00, which would look like a NULL
    // spacer; trust them only once they have filled with real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_NULL;
            zp      <= 1'b0;
            parity0 <= 1'b0;
            parity1 <= 1'b0;
        end else begin
            case (state)
                WAIT_NULL: begin
                    if (vld_pipe[STAGES] && rails_s == 2'b00) state <= IDLE;
                end
                IDLE: begin
                    // Outputs decoded from the post-update parity so they appear with the state change
                    case (rails_s)
                        2'b01: begin
                            zp      <= ~zp;
                            parity0 <= zp;
                            parity1 <= ~zp;
                            state   <= ACK;
                        end
                        2'b10: begin
                            parity0 <= ~zp;
                            parity1 <= zp;
                            state   <= ACK;
                        end
                        default: state <= IDLE;
                    endcase
                end
                ACK: begin
                    if (rails_s == 2'b00) begin
                        parity0 <= 1'b0;
                        parity1 <= 1'b0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: begin
                    parity0 <= 1'b0;
                    parity1 <= 1'b0;
                    state   <= WAIT_NULL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_evenzeroes_struct_imp.sv
// Directed and protocol-random bench for the dual-rail even-zeroes tracker.

module tb_evenzeroes_struct_imp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit0 = 1'b0;
    logic bit1 = 1'b0;
    logic parity0, parity1;
    int   errors = 0;
    int   checks = 0;
    int   both_hi = 0;

    evenzeroes_struct_imp #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit0    (bit0),
        .bit1    (bit1),
        .parity0 (parity0),
        .parity1 (parity1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (parity0 && parity1) both_hi++;

    task automatic put(input logic [1:0] v);
        @(negedge clk);
        {bit1, bit0} = v;
    endtask

    // Count edges until the outputs reach the wanted phase; 99 means timeout.
    task automatic wait_out(input bit want_data, output int n, output logic [1:0] obs);
        n = 99;
        obs = {parity1, parity0};
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            obs = {parity1, parity0};
            if ((obs != 2'b00) == want_data) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {bit1, bit0} = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({parity1, parity0} !== 2'b00) begin
            errors++;
            $display("FAIL reset_out: got %b want 00", {parity1, parity0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({parity1, parity0} !== 2'b00) begin
                errors++;
                $display("FAIL idle_null cyc%0d: got %b want 00", i, {parity1, parity0});
            end
        end
    endtask

    task automatic test_zero_twice();
        int n;
        logic [1:0] obs;
        do_reset();
        put(2'b01);
        wait_out(1'b1, n, obs);
        checks++;
        if (n !== 3 || obs !== 2'b10) begin
            errors++;
            $display("FAIL first_zero: got lat=%0d out=%b want lat=3 out=10", n, obs);
        end
        put(2'b00);
        wait_out(1'b0, n, obs);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL null_latency: got %0d want 3", n);
        end
        put(2'b01);
        wait_out(1'b1, n, obs);
        checks++;
        if (n !== 3 || obs !== 2'b01) begin
            errors++;
            $display("FAIL second_zero: got lat=%0d out=%b want lat=3 out=01", n, obs);
        end
        put(2'b00);
        wait_out(1'b0, n, obs);
    endtask

    task automatic test_ones();
        int n;
        logic [1:0] obs;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            put(2'b10);
            wait_out(1'b1, n, obs);
            checks++;
            if (n !== 3 || obs !== 2'b01) begin
                errors++;
                $display("FAIL one_%0d: got lat=%0d out=%b want lat=3 out=01", k, n, obs);
            end
            put(2'b00);
            wait_out(1'b0, n, obs);
        end
        put(2'b01);
        wait_out(1'b1, n, obs);
        checks++;
        if (obs !== 2'b10) begin
            errors++;
            $display("FAIL zero_after_ones: got %b want 10", obs);
        end
        // Switching rails during ACK must not change the held answer.
        put(2'b10);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({parity1, parity0} !== 2'b10) begin
                errors++;
                $display("FAIL ack_hold cyc%0d: got %b want 10", i, {parity1, parity0});
            end
        end
        put(2'b00);
        wait_out(1'b0, n, obs);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL release_after_swap: got lat=%0d want 3", n);
        end
    endtask

    task automatic test_illegal();
        int n;
        logic [1:0] obs;
        do_reset();
        put(2'b11);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({parity1, parity0} !== 2'b00) begin
                errors++;
                $display("FAIL illegal cyc%0d: got %b want 00", i, {parity1, parity0});
            end
        end
        put(2'b01);
        wait_out(1'b1, n, obs);
        checks++;
        if (n !== 3 || obs !== 2'b10) begin
            errors++;
            $display("FAIL after_illegal: got lat=%0d out=%b want lat=3 out=10", n, obs);
        end
        put(2'b00);
        wait_out(1'b0, n, obs);
    endtask

    task automatic test_reset_mid_ack();
        int n;
        logic [1:0] obs;
        do_reset();
        put(2'b01);
        wait_out(1'b1, n, obs);
        checks++;
        if (obs !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_ack: got %b want 10", obs);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({parity1, parity0} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got %b want 00", {parity1, parity0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({parity1, parity0} !== 2'b00) begin
                errors++;
                $display("FAIL stale_token cyc%0d: got %b want 00", i, {parity1, parity0});
            end
        end
        put(2'b00);
        repeat (5) @(negedge clk);
        put(2'b01);
        wait_out(1'b1, n, obs);
        checks++;
        if (n !== 3 || obs !== 2'b10) begin
            errors++;
            $display("FAIL restart_odd: got lat=%0d out=%b want lat=3 out=10", n, obs);
        end
        put(2'b00);
        wait_out(1'b0, n, obs);
    endtask

    task automatic test_random();
        int n;
        logic [1:0] obs;
        logic [1:0] v;
        logic [1:0] want;
        bit ref_zp;
        do_reset();
        ref_zp = 1'b0;
        for (int k = 0; k < 200; k++) begin
            v = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            if (v == 2'b01) ref_zp = ~ref_zp;
            want = ref_zp ? 2'b10 : 2'b01;
            put(v);
            wait_out(1'b1, n, obs);
            checks++;
            if (n !== 3 || obs !== want) begin
                errors++;
                $display("FAIL rand_ack_%0d: got lat=%0d out=%b want lat=3 out=%b", k, n, obs, want);
            end
            put(2'b00);
            wait_out(1'b0, n, obs);
            checks++;
            if (n !== 3) begin
                errors++;
                $display("FAIL rand_null_%0d: got lat=%0d want 3", k, n);
            end
        end
        checks++;
        if (both_hi !== 0) begin
            errors++;
            $display("FAIL both_rails_high: got %0d cycles want 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_zero_twice();
        test_ones();
        test_illegal();
        test_reset_mid_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
